// File: rtl/spi_inert_resp.sv
// spi_inert_resp: SPI peripheral model of the inertial sensor.
// 16-bit mode-0 frames, small register map, periodic samples, INT line.
module spi_inert_resp #(
   parameter logic [15:0]        PERIOD    = 16'd2048,
   parameter logic signed [15:0] PTCH_STEP = 16'sd3,
   parameter logic signed [15:0] ROLL_STEP = -16'sd2,
   parameter logic signed [15:0] YAW_STEP  = 16'sd5,
   parameter logic [7:0]         WHO_AM_I  = 8'h6A
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic SCLK,
   input  logic MOSI,
   output logic MISO,
   output logic INT,
   output logic int_en
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic ss_q1;
   logic ss_q2;
   logic ss_d;
   logic sclk_q1;
   logic sclk_q2;
   logic sclk_d;
   logic mosi_q1;
   logic mosi_q2;

   logic sclk_rise;
   logic sclk_fall;
   logic ss_rise;
   logic ss_fall;

   logic [3:0]  bit_cnt;
   logic [6:0]  rx_sr;
   logic [7:0]  shreg;
   logic        rw;
   logic [6:0]  addr;
   logic [6:0]  addr_nxt;
   logic [7:0]  wr_data;
   logic [7:0]  rd_byte;
   logic        addr_done;
   logic        frame_end;
   logic        wr_en;
   logic        int_clr;

   logic [7:0]  int_ctrl;
   logic [7:0]  ctrl1;
   logic [7:0]  ctrl2;
   logic [15:0] ptch;
   logic [15:0] roll;
   logic [15:0] yaw;

   logic [15:0] cnt;
   logic        wrap;
   logic        ev;
   logic        upd;
   logic        pend;
   logic        int_q;

   // Synchronizers reset low so a select held low through reset
   // produces no falling edge until it has been seen high first.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_q1   <= 1'b0;
         ss_q2   <= 1'b0;
         ss_d    <= 1'b0;
         sclk_q1 <= 1'b0;
         sclk_q2 <= 1'b0;
         sclk_d  <= 1'b0;
         mosi_q1 <= 1'b0;
         mosi_q2 <= 1'b0;
      end else begin
         ss_q1   <= SS_n;
         ss_q2   <= ss_q1;
         ss_d    <= ss_q2;
         sclk_q1 <= SCLK;
         sclk_q2 <= sclk_q1;
         sclk_d  <= sclk_q2;
         mosi_q1 <= MOSI;
         mosi_q2 <= mosi_q1;
      end
   end

   assign sclk_rise = sclk_q2 & ~sclk_d;
   assign sclk_fall = ~sclk_q2 & sclk_d;
   assign ss_rise   = ss_q2 & ~ss_d;
   assign ss_fall   = ~ss_q2 & ss_d;

   assign addr_nxt  = {rx_sr[5:0], mosi_q2};
   assign wr_data   = {rx_sr, mosi_q2};
   assign addr_done = (state == ADDR) & sclk_rise & ~ss_rise
                    & (bit_cnt == 4'd7);
   assign frame_end = (state == DATA) & sclk_rise & ~ss_rise
                    & (bit_cnt == 4'd15);
   assign wr_en     = frame_end & ~rw;
   assign int_clr   = frame_end & rw & (addr == 7'h27);

   // Frame state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame sequencing; a select rise outside DONE aborts the frame.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (ss_fall) begin
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (ss_rise) begin
               state_nxt = IDLE;
            end else if (addr_done) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (ss_rise) begin
               state_nxt = IDLE;
            end else if (frame_end) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (ss_rise) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Register read mux, addressed by the address byte being completed.
   always_comb begin
      rd_byte = 8'h00;
      unique case (addr_nxt)
         7'h0D:   rd_byte = int_ctrl;
         7'h0F:   rd_byte = WHO_AM_I;
         7'h10:   rd_byte = ctrl1;
         7'h11:   rd_byte = ctrl2;
         7'h22:   rd_byte = ptch[7:0];
         7'h23:   rd_byte = ptch[15:8];
         7'h24:   rd_byte = roll[7:0];
         7'h25:   rd_byte = roll[15:8];
         7'h26:   rd_byte = yaw[7:0];
         7'h27:   rd_byte = yaw[15:8];
         default: rd_byte = 8'h00;
      endcase
   end

   // Shift path: MOSI in on rises, MISO out on falls. The first fall
   // of the data byte is skipped so bit 7 is held for the 9th rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= 4'd0;
         rx_sr   <= 7'd0;
         shreg   <= 8'd0;
         rw      <= 1'b0;
         addr    <= 7'd0;
      end else if (state == IDLE) begin
         bit_cnt <= 4'd0;
         shreg   <= 8'd0;
      end else if ((state == ADDR) || (state == DATA)) begin
         if (sclk_rise) begin
            rx_sr   <= addr_nxt;
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (addr_done) begin
            rw   <= rx_sr[6];
            addr <= addr_nxt;
            if (rx_sr[6]) begin
               shreg <= rd_byte;
            end
         end else if (sclk_fall
                      && !((state == DATA) && (bit_cnt == 4'd8))) begin
            shreg <= {shreg[6:0], 1'b0};
         end
      end
   end

   // Writable registers, committed only on a complete write frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_ctrl <= 8'h00;
         ctrl1    <= 8'h00;
         ctrl2    <= 8'h00;
      end else if (wr_en) begin
         unique case (addr)
            7'h0D:   int_ctrl <= wr_data;
            7'h10:   ctrl1    <= wr_data;
            7'h11:   ctrl2    <= wr_data;
            default: ;
         endcase
      end
   end

   // Free-running sample period counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 16'd0;
      end else if (wrap) begin
         cnt <= 16'd0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   assign wrap = (cnt == (PERIOD - 16'd1));
   assign ev   = wrap & int_ctrl[1];
   assign upd  = ss_q2 & (ev | pend);

   // One deferred event is held while selected; extra ones are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 1'b0;
      end else if (upd) begin
         pend <= 1'b0;
      end else if (ev && !ss_q2) begin
         pend <= 1'b1;
      end
   end

   // Sample update, never while a frame is selected.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptch <= 16'h0000;
         roll <= 16'h0000;
         yaw  <= 16'h0000;
      end else if (upd) begin
         ptch <= ptch + $unsigned(PTCH_STEP);
         roll <= roll + $unsigned(ROLL_STEP);
         yaw  <= yaw + $unsigned(YAW_STEP);
      end
   end

   // Data-ready flag: set beats clear, disabled forces low.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_q <= 1'b0;
      end else if (!int_ctrl[1]) begin
         int_q <= 1'b0;
      end else if (upd) begin
         int_q <= 1'b1;
      end else if (int_clr) begin
         int_q <= 1'b0;
      end
   end

   assign INT    = int_q & int_ctrl[1];
   assign int_en = int_ctrl[1];
   assign MISO   = ~SS_n & shreg[7];

endmodule

// File: tb/tb_spi_inert_resp.sv
// tb_spi_inert_resp: directed plan plus random frames against a
// register-map and event-count model of the sensor.
module tb_spi_inert_resp;

   localparam int P = 2048;

   logic clk = 1'b0;
   logic rst;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;
   logic INT;
   logic int_en;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [7:0] m_intc;
   logic [7:0] m_c1;
   logic [7:0] m_c2;
   int         m_ev;
   int         m_wraps;
   logic       m_int;

   spi_inert_resp dut (
      .clk    (clk),
      .rst    (rst),
      .SS_n   (SS_n),
      .SCLK   (SCLK),
      .MOSI   (MOSI),
      .MISO   (MISO),
      .INT    (INT),
      .int_en (int_en)
   );

   always #5 clk = ~clk;

   // Clocks since reset release; sample events fall on multiples of P.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_intc  = 8'h00;
      m_c1    = 8'h00;
      m_c2    = 8'h00;
      m_ev    = 0;
      m_wraps = 0;
      m_int   = 1'b0;
   endtask

   function automatic logic [7:0] m_read(input logic [6:0] a);
      logic [15:0] p;
      logic [15:0] r;
      logic [15:0] y;
      p = 16'(3 * m_ev);
      r = 16'(-2 * m_ev);
      y = 16'(5 * m_ev);
      case (a)
         7'h0D:   return m_intc;
         7'h0F:   return 8'h6A;
         7'h10:   return m_c1;
         7'h11:   return m_c2;
         7'h22:   return p[7:0];
         7'h23:   return p[15:8];
         7'h24:   return r[7:0];
         7'h25:   return r[15:8];
         7'h26:   return y[7:0];
         7'h27:   return y[15:8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_write(input logic [6:0] a, input logic [7:0] d);
      case (a)
         7'h0D: begin
            m_intc = d;
            if (!d[1]) m_int = 1'b0;
         end
         7'h10:   m_c1 = d;
         7'h11:   m_c2 = d;
         default: ;
      endcase
   endtask

   task automatic process_wraps();
      int w;
      w = cyc / P;
      while (m_wraps < w) begin
         m_wraps++;
         if (m_intc[1]) begin
            m_ev++;
            m_int = 1'b1;
         end
      end
   endtask

   task automatic wait_safe();
      while (((cyc % P) > (P - 320)) || ((cyc % P) < 12))
         @(negedge clk);
   endtask

   task automatic spi_xfer(input logic [15:0] tx, input int nbits,
                           input int h, input int rst_at,
                           input bit close, output logic [7:0] rx);
      logic [7:0] r;
      int i;
      r = 8'h00;
      SS_n = 1'b0;
      repeat (h) @(negedge clk);
      for (int k = 0; k < nbits; k++) begin
         i = 15 - k;
         if (k == rst_at) begin
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            m_reset();
         end
         MOSI = tx[i];
         repeat (h) @(negedge clk);
         SCLK = 1'b1;
         if (i < 8) r[i] = MISO;
         repeat (h) @(negedge clk);
         SCLK = 1'b0;
      end
      repeat (h) @(negedge clk);
      if (close) begin
         SS_n = 1'b1;
         MOSI = 1'b0;
         repeat (h + 4) @(negedge clk);
      end
      rx = r;
   endtask

   task automatic rd(input logic [6:0] a, input int h,
                     output logic [7:0] d);
      logic [7:0] e;
      wait_safe();
      process_wraps();
      chk("int", {31'd0, INT}, {31'd0, m_int & m_intc[1]});
      chk("int_en", {31'd0, int_en}, {31'd0, m_intc[1]});
      e = m_read(a);
      spi_xfer({1'b1, a, 8'h00}, 16, h, -1, 1'b1, d);
      chk($sformatf("rd_%02h", a), {24'd0, d}, {24'd0, e});
      if (a == 7'h27) m_int = 1'b0;
      chk("miso_idle", {31'd0, MISO}, 32'd0);
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] v,
                     input int h);
      logic [7:0] d;
      wait_safe();
      process_wraps();
      spi_xfer({1'b0, a, v}, 16, h, -1, 1'b1, d);
      m_write(a, v);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] b [6];
      logic [7:0] e;
      logic [6:0] a;
      logic [7:0] v;
      logic [6:0] alist [12];
      int h;

      rst  = 1'b1;
      SS_n = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      m_reset();
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_miso", {31'd0, MISO}, 32'd0);
      chk("rst_int", {31'd0, INT}, 32'd0);
      chk("rst_int_en", {31'd0, int_en}, 32'd0);

      rd(7'h0F, 4, d);
      chk("who_am_i", {24'd0, d}, 32'h6A);

      wr(7'h0D, 8'h02, 4);
      rd(7'h0D, 4, d);
      chk("int_ctrl", {24'd0, d}, 32'h02);
      chk("int_en_on", {31'd0, int_en}, 32'd1);

      while ((cyc % P) != (P - 2)) @(negedge clk);
      chk("int_pre_evt", {31'd0, INT}, 32'd0);
      while ((cyc % P) != 2) @(negedge clk);
      chk("int_at_evt", {31'd0, INT}, 32'd1);

      for (int k = 0; k < 6; k++) rd(7'(7'h22 + k), 4, b[k]);
      chk("pitch1", {16'd0, b[1], b[0]}, 32'h0003);
      chk("roll1", {16'd0, b[3], b[2]}, 32'hFFFE);
      chk("yaw1", {16'd0, b[5], b[4]}, 32'h0005);
      chk("int_cleared", {31'd0, INT}, 32'd0);

      while (cyc < (2 * P + 4)) @(negedge clk);
      chk("int_evt2", {31'd0, INT}, 32'd1);
      for (int k = 0; k < 6; k++) rd(7'(7'h22 + k), 4, b[k]);
      chk("pitch2", {16'd0, b[1], b[0]}, 32'h0006);
      chk("roll2", {16'd0, b[3], b[2]}, 32'hFFFC);
      chk("yaw2", {16'd0, b[5], b[4]}, 32'h000A);

      wait_safe();
      process_wraps();
      spi_xfer(16'h105A, 10, 5, -1, 1'b1, d);
      chk("abort_miso", {31'd0, MISO}, 32'd0);
      rd(7'h10, 5, d);
      chk("ctrl1_abort", {24'd0, d}, 32'h00);

      rd(7'h27, 4, d);
      while ((cyc % P) != (P - 100)) @(negedge clk);
      process_wraps();
      e = m_read(7'h22);
      chk("int_pre_defer", {31'd0, INT}, 32'd0);
      spi_xfer(16'hA200, 16, 5, -1, 1'b0, d);
      chk("defer_seen", {31'd0, 32'((cyc % P) < 200)}, 32'd1);
      chk("int_deferred", {31'd0, INT}, 32'd0);
      chk("rd22_pre", {24'd0, d}, {24'd0, e});
      SS_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("int_applied", {31'd0, INT}, 32'd1);
      repeat (8) @(negedge clk);
      process_wraps();
      rd(7'h22, 5, d);

      wait_safe();
      process_wraps();
      spi_xfer(16'h11A5, 16, 5, 5, 1'b1, d);
      chk("rst_mid_int", {31'd0, INT}, 32'd0);
      chk("rst_mid_en", {31'd0, int_en}, 32'd0);
      rd(7'h11, 5, d);
      chk("ctrl2_rst", {24'd0, d}, 32'h00);
      rd(7'h0F, 5, d);
      chk("who_after_rst", {24'd0, d}, 32'h6A);

      alist = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h22, 7'h23,
                7'h24, 7'h25, 7'h26, 7'h27, 7'h0E, 7'h00};
      for (int n = 0; n < 48; n++) begin
         a = alist[$urandom_range(0, 11)];
         if (a == 7'h00) a = 7'($urandom_range(0, 127));
         h = $urandom_range(4, 7);
         v = 8'($urandom_range(0, 255));
         if (a == 7'h0D) begin
            if ($urandom_range(0, 4) != 0) v = v | 8'h02;
            else                           v = v & 8'hFD;
         end
         case ($urandom_range(0, 7))
            0: begin
               wait_safe();
               process_wraps();
               spi_xfer({1'($urandom_range(0, 1)), a, v},
                        $urandom_range(1, 15), h, -1, 1'b1, d);
            end
            1, 2, 3: wr(a, v, h);
            default: rd(a, h, d);
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
